// File: rtl/iq_chirp_sequencer.sv
// Burst/gap sequencer that drives a quadratic-phase (linear chirp) word to
// an IQ modulator. All outputs are registered from the next-state values.
module iq_chirp_sequencer #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16,
    parameter int REP_W  = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_gap,
    input  logic [REP_W-1:0]  cfg_rep,
    input  logic [ADDR_W-1:0] cfg_step,
    input  logic [ADDR_W-1:0] cfg_rate,
    output logic              en_out,
    output logic [ADDR_W-1:0] step_out,
    output logic [ADDR_W-1:0] mod_phase_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [2:0]        state_out
);

    // start_in is a one-cycle request taken only in IDLE with abort_in low;
    // abort_in is a level that wins over every other transition.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_BURST = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [ADDR_W-1:0]  step_q, step_d;
    logic [ADDR_W-1:0]  rate_q, rate_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   gcnt_q, gcnt_d;
    logic [REP_W-1:0]   bcnt_q, bcnt_d;
    logic [ADDR_W-1:0]  p_q, p_d;
    logic [ADDR_W-1:0]  f_q, f_d;
    logic               en_q, en_d;
    logic [ADDR_W-1:0]  phase_q, phase_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        gap_d   = gap_q;
        rep_d   = rep_q;
        step_d  = step_q;
        rate_d  = rate_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        bcnt_d  = bcnt_q;
        p_d     = p_q;
        f_d     = f_q;

        case (state_q)
            S_IDLE: begin
                if (start_in && !abort_in && (cfg_len != '0)) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                len_d   = cfg_len;
                gap_d   = cfg_gap;
                rep_d   = cfg_rep;
                step_d  = cfg_step;
                rate_d  = cfg_rate;
                cnt_d   = '0;
                gcnt_d  = '0;
                bcnt_d  = '0;
                p_d     = '0;
                f_d     = '0;
                state_d = S_BURST;
            end
            S_BURST: begin
                if (cnt_q == len_q - CNT_ONE) begin
                    // Phase and frequency restart so every burst is the same chirp.
                    bcnt_d = bcnt_q + REP_ONE;
                    cnt_d  = '0;
                    p_d    = '0;
                    f_d    = '0;
                    if ((rep_q != '0) && (bcnt_d == rep_q)) begin
                        state_d = S_DONE;
                    end else if (gap_q == '0) begin
                        state_d = S_BURST;
                    end else begin
                        gcnt_d  = '0;
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    p_d   = p_q + f_q;
                    f_d   = f_q + rate_q;
                end
            end
            S_GAP: begin
                if (gcnt_q == gap_q - CNT_ONE) begin
                    gcnt_d  = '0;
                    state_d = S_BURST;
                end else begin
                    gcnt_d = gcnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_in && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end

        en_d    = (state_d == S_BURST);
        phase_d = en_d ? p_d : '0;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            gap_q   <= '0;
            rep_q   <= '0;
            step_q  <= '0;
            rate_q  <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            bcnt_q  <= '0;
            p_q     <= '0;
            f_q     <= '0;
            en_q    <= 1'b0;
            phase_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            rep_q   <= rep_d;
            step_q  <= step_d;
            rate_q  <= rate_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            bcnt_q  <= bcnt_d;
            p_q     <= p_d;
            f_q     <= f_d;
            en_q    <= en_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign en_out        = en_q;
    assign step_out      = step_q;
    assign mod_phase_out = phase_q;
    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_iq_chirp_sequencer.sv
// Self-checking bench for iq_chirp_sequencer: per-cycle expected trace of
// {busy, done, en, phase} is queued from a closed-form chirp model.
module tb_iq_chirp_sequencer;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;
    localparam int REP_W  = 8;
    localparam int EW     = ADDR_W + 3;

    logic              clk_in;
    logic              rst_in;
    logic              start_in;
    logic              abort_in;
    logic [CNT_W-1:0]  cfg_len;
    logic [CNT_W-1:0]  cfg_gap;
    logic [REP_W-1:0]  cfg_rep;
    logic [ADDR_W-1:0] cfg_step;
    logic [ADDR_W-1:0] cfg_rate;
    logic              en_out;
    logic [ADDR_W-1:0] step_out;
    logic [ADDR_W-1:0] mod_phase_out;
    logic              busy_out;
    logic              done_out;
    logic [2:0]        state_out;

    logic [EW-1:0] exp_q[$];
    int n_checks;
    int n_pass;

    iq_chirp_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .start_in      (start_in),
        .abort_in      (abort_in),
        .cfg_len       (cfg_len),
        .cfg_gap       (cfg_gap),
        .cfg_rep       (cfg_rep),
        .cfg_step      (cfg_step),
        .cfg_rate      (cfg_rate),
        .en_out        (en_out),
        .step_out      (step_out),
        .mod_phase_out (mod_phase_out),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .state_out     (state_out)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] exp_phase(input int rate, input int k);
        longint v;
        v = longint'(rate) * longint'(k) * longint'(k - 1) / 2;
        return ADDR_W'(v % 1024);
    endfunction

    // Drains the queue one cycle at a time; at poke_at a start pulse and
    // random config are driven, which the busy DUT must ignore.
    task automatic drain_trace(input int poke_at);
        int n;
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            if (i == poke_at) begin
                start_in = 1'b1;
                cfg_len  = CNT_W'($urandom_range(3, 9));
                cfg_gap  = CNT_W'($urandom_range(1, 5));
                cfg_rep  = REP_W'($urandom_range(1, 3));
                cfg_rate = ADDR_W'($urandom_range(1, 1023));
                cfg_step = ADDR_W'($urandom_range(0, 1023));
            end else begin
                start_in = 1'b0;
            end
            got = {busy_out, done_out, en_out, mod_phase_out};
            exp = exp_q.pop_front();
            check_eq("trace", 32'(got), 32'(exp));
        end
        start_in = 1'b0;
    endtask

    task automatic kick(input int len, input int gap, input int rep, input int rate, input int step);
        cfg_len  = CNT_W'(len);
        cfg_gap  = CNT_W'(gap);
        cfg_rep  = REP_W'(rep);
        cfg_rate = ADDR_W'(rate);
        cfg_step = ADDR_W'(step);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        check_eq("load_busy", 32'(busy_out), 32'd1);
        check_eq("load_en", 32'(en_out), 32'd0);
    endtask

    task automatic run_seq(input int len, input int gap, input int rep, input int rate,
                           input int step, input int poke_at);
        kick(len, gap, rep, rate, step);
        for (int b = 0; b < rep; b++) begin
            for (int k = 0; k < len; k++) exp_q.push_back({1'b1, 1'b0, 1'b1, exp_phase(rate, k)});
            if (b < rep - 1) begin
                for (int g = 0; g < gap; g++) exp_q.push_back({1'b1, 1'b0, 1'b0, {ADDR_W{1'b0}}});
            end
        end
        exp_q.push_back({1'b1, 1'b1, 1'b0, {ADDR_W{1'b0}}});
        exp_q.push_back({1'b0, 1'b0, 1'b0, {ADDR_W{1'b0}}});
        drain_trace(poke_at);
        check_eq("step_hold", 32'(step_out), 32'(step));
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_in);
            check_eq(tag, 32'({busy_out, done_out, en_out}), 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_in   = 1'b1;
        start_in = 1'b0;
        abort_in = 1'b0;
        cfg_len  = '0;
        cfg_gap  = '0;
        cfg_rep  = '0;
        cfg_step = '0;
        cfg_rate = '0;
        #2 rst_in = 1'b0;
        #1;
        check_eq("rst_en", 32'(en_out), 32'd0);
        check_eq("rst_busy", 32'(busy_out), 32'd0);
        check_eq("rst_done", 32'(done_out), 32'd0);
        check_eq("rst_phase", 32'(mod_phase_out), 32'd0);
        check_eq("rst_step", 32'(step_out), 32'd0);
        check_eq("rst_state", 32'(state_out), 32'd0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        expect_idle("idle_after_rst", 2);

        // Basic chirp: phases 0,0,1,3, then done
        run_seq(4, 0, 1, 1, 5, -1);
        // Two bursts with a gap; start pulse mid-run must be ignored
        run_seq(3, 2, 2, 4, 77, 4);
        // Wrap check with a large rate
        run_seq(64, 0, 1, 1023, 300, 10);
        // Back-to-back bursts with no gap, three of them
        run_seq(5, 0, 3, 37, 12, 7);

        // Zero-length start and start+abort in IDLE are ignored
        cfg_len  = '0;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        expect_idle("len0_ignored", 3);
        cfg_len  = CNT_W'(4);
        start_in = 1'b1;
        abort_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        abort_in = 1'b0;
        expect_idle("start_abort_idle", 3);

        // Continuous mode, then abort
        kick(2, 0, 0, 7, 9);
        for (int i = 0; i < 1000; i++) exp_q.push_back({1'b1, 1'b0, 1'b1, exp_phase(7, i % 2)});
        drain_trace(100);
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        check_eq("abort_en", 32'(en_out), 32'd0);
        check_eq("abort_done", 32'(done_out), 32'd0);
        check_eq("abort_busy", 32'(busy_out), 32'd0);
        expect_idle("post_abort", 4);
        check_eq("abort_step_hold", 32'(step_out), 32'd9);

        // Reset asserted mid-burst clears outputs without a clock edge
        kick(20, 0, 1, 5, 3);
        repeat (5) @(negedge clk_in);
        check_eq("midburst_en", 32'(en_out), 32'd1);
        #2 rst_in = 1'b0;
        #1;
        check_eq("arst_outs", 32'({en_out, busy_out, done_out}), 32'd0);
        check_eq("arst_phase", 32'(mod_phase_out), 32'd0);
        check_eq("arst_step", 32'(step_out), 32'd0);
        check_eq("arst_state", 32'(state_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        expect_idle("post_rst_wait", 5);
        run_seq(4, 0, 1, 1, 21, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iq_chirp_sequencer.md
IQ_CHIRP_SEQUENCER -- requirements
Module: iq_chirp_sequencer

Interface
REQ-001 Parameter ADDR_W, default 10: width of phase/step words; sets the modulo-2^ADDR_W LUT address space.
REQ-002 Parameter CNT_W, default 16: width of burst-length and gap counters.
REQ-003 Parameter REP_W, default 8: width of burst-repeat count.
REQ-004 clk_in  input  1  sole clock; all logic on rising edge.
REQ-005 rst_in  input  1  reset, asynchronous assert, active-low.
REQ-006 start_in  input  1  single-cycle start request; honoured only in IDLE.
REQ-007 abort_in  input  1  level; forces return to IDLE.
REQ-008 cfg_len  input  CNT_W  samples per burst.
REQ-009 cfg_gap  input  CNT_W  idle samples between bursts.
REQ-010 cfg_rep  input  REP_W  burst count; 0 = continuous.
REQ-011 cfg_step  input  ADDR_W  carrier step forwarded to modulator.
REQ-012 cfg_rate  input  ADDR_W  chirp rate (frequency increment per sample).
REQ-013 en_out  output  1  modulator enable; high only during burst samples.
REQ-014 step_out  output  ADDR_W  latched cfg_step.
REQ-015 mod_phase_out  output  ADDR_W  chirp phase word to modulator phase_I/phase_Q inputs.
REQ-016 busy_out  output  1  high in every state except IDLE.
REQ-017 done_out  output  1  one-cycle pulse at normal sequence completion.

Function
REQ-018 The block SHALL implement states IDLE, LOAD, BURST, GAP, DONE; all outputs registered.
REQ-019 IDLE: start_in=1 with cfg_len!=0 SHALL move to LOAD next cycle; start_in with cfg_len=0 SHALL be ignored (stay IDLE, no done_out).
REQ-020 LOAD (one cycle): latch cfg_len, cfg_gap, cfg_rep, cfg_step, cfg_rate; clear sample, gap, burst counters; clear phase p and frequency f; next state BURST.
REQ-021 Config inputs SHALL be ignored outside LOAD; changes mid-sequence have no effect.
REQ-022 BURST: en_out=1 for exactly latched cfg_len consecutive cycles; each cycle mod_phase_out=p, then p<=p+f, f<=f+rate, all mod 2^ADDR_W (wrap, no saturation).
REQ-023 Resulting burst sample k (0-based) SHALL give mod_phase_out = rate*k*(k-1)/2 mod 2^ADDR_W; p and f SHALL reset to 0 at each burst start.
REQ-024 End of burst: burst counter +1; if cfg_rep!=0 and count==cfg_rep -> DONE; else if cfg_gap=0 -> next BURST directly (en_out stays high, no dead cycle); else -> GAP.
REQ-025 GAP: en_out=0, mod_phase_out=0, for exactly cfg_gap cycles, then BURST.
REQ-026 DONE: done_out=1 for one cycle, en_out=0, then IDLE.
REQ-027 cfg_rep=0 SHALL repeat BURST/GAP indefinitely; burst counter SHALL not terminate the sequence on wrap.
REQ-028 abort_in=1 in any non-IDLE state SHALL go to IDLE next cycle; en_out=0 that cycle; done_out not asserted; abort has priority over all transitions.
REQ-029 start_in while busy_out=1 SHALL be ignored; start_in and abort_in both high in IDLE: start ignored.
REQ-030 step_out SHALL hold latched value in all states, including IDLE after completion or abort.
REQ-031 Latency: start_in at edge N -> busy_out at N+1, first en_out=1 at N+2.

Reset
REQ-032 rst_in low SHALL immediately force state IDLE, en_out=0, busy_out=0, done_out=0, step_out=0, mod_phase_out=0, all counters, p, f cleared.
REQ-033 Reset asserted mid-burst SHALL abort without done_out; after release block waits for new start_in.

Verification
REQ-034 cfg_len=4, cfg_rate=1, cfg_rep=1, cfg_gap=0, start -> en_out high 4 cycles from N+2, mod_phase_out 0,0,1,3, done_out one cycle after, then IDLE.
REQ-035 cfg_len=3, cfg_gap=2, cfg_rep=2, cfg_rate=4 -> en pattern 1,1,1,0,0,1,1,1 then done_out; phase 0,0,4 in each burst.
REQ-036 cfg_len=64, cfg_rate=1023 (ADDR_W=10) -> phase matches rate*k*(k-1)/2 mod 1024 every sample (wrap check).
REQ-037 cfg_rep=0, cfg_len=2, cfg_gap=0 -> en_out continuously high 1000 cycles; abort_in -> en_out=0 next cycle, no done_out.
REQ-038 rst_in low mid-burst -> all outputs zero asynchronously; start_in during busy and cfg_len=0 start both ignored.
